// File: rtl/dumbrv_gpio_ext.sv
// GPIO block on the stray bus: OUT/OE pin drive, synchronised IN with sticky
// rise/fall flags and a level interrupt, behind a level-request / done-pulse handshake.
module dumbrv_gpio_ext #(
    parameter int          GPIO_W      = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] BASE_ADDR   = 16'hF000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stray_en_i,
    input  logic              stray_wr_i,
    input  logic [15:0]       stray_addr_i,
    input  logic [2:0]        stray_size_i,
    input  logic [31:0]       stray_data_i,
    output logic [31:0]       stray_data_o,
    output logic              stray_done_o,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_oe_o,
    output logic              irq_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [2:0] REG_OUT   = 3'd0;
    localparam logic [2:0] REG_OE    = 3'd1;
    localparam logic [2:0] REG_IN    = 3'd2;
    localparam logic [2:0] REG_RISE  = 3'd3;
    localparam logic [2:0] REG_FALL  = 3'd4;
    localparam logic [2:0] REG_IRQEN = 3'd5;
    localparam logic [2:0] REG_SET   = 3'd6;
    localparam logic [2:0] REG_CLR   = 3'd7;

    state_t            state_r;
    logic [31:0]       data_r;
    logic              done_r;
    logic              irq_r;
    logic [GPIO_W-1:0] out_r;
    logic [GPIO_W-1:0] oe_r;
    logic [GPIO_W-1:0] rise_r;
    logic [GPIO_W-1:0] fall_r;
    logic [GPIO_W-1:0] irqen_r;
    logic [GPIO_W-1:0] prev_r;
    logic [GPIO_W-1:0] sync_r [SYNC_STAGES];

    logic [4:0]        shift_s;
    logic [2:0]        reg_sel_s;
    logic              hit_s;
    logic              aligned_s;
    logic              acc_ok_s;
    logic              do_wr_s;
    logic [3:0]        lane_s;
    logic [31:0]       lane_mask_s;
    logic [31:0]       size_mask_s;
    logic [31:0]       wdata_s;
    logic [31:0]       rreg_s;
    logic [31:0]       rdata_s;
    logic [GPIO_W-1:0] wbits_s;
    logic [GPIO_W-1:0] wmask_s;
    logic [GPIO_W-1:0] in_s;
    logic [GPIO_W-1:0] out_nxt_s;
    logic [GPIO_W-1:0] oe_nxt_s;
    logic [GPIO_W-1:0] irqen_nxt_s;
    logic [GPIO_W-1:0] rise_clr_s;
    logic [GPIO_W-1:0] fall_clr_s;
    logic [GPIO_W-1:0] rise_nxt_s;
    logic [GPIO_W-1:0] fall_nxt_s;
    logic              irq_nxt_s;

    function automatic logic [31:0] zext(input logic [GPIO_W-1:0] v);
        logic [31:0] w;
        w = 32'd0;
        w[GPIO_W-1:0] = v;
        return w;
    endfunction

    assign in_s    = sync_r[SYNC_STAGES-1];
    assign do_wr_s = (state_r == IDLE) & stray_en_i & stray_wr_i & acc_ok_s;

    // Address window, alignment and byte-lane decode of the current request
    always_comb begin
        shift_s     = {stray_addr_i[1:0], 3'b000};
        reg_sel_s   = stray_addr_i[4:2];
        hit_s       = (stray_addr_i[15:5] == BASE_ADDR[15:5]);
        lane_mask_s = 32'd0;
        case (stray_size_i)
            3'd0: begin
                aligned_s   = 1'b1;
                lane_s      = 4'b0001 << stray_addr_i[1:0];
                size_mask_s = 32'h0000_00FF;
            end
            3'd1: begin
                aligned_s   = ~stray_addr_i[0];
                lane_s      = 4'b0011 << stray_addr_i[1:0];
                size_mask_s = 32'h0000_FFFF;
            end
            3'd2: begin
                aligned_s   = (stray_addr_i[1:0] == 2'b00);
                lane_s      = 4'b1111;
                size_mask_s = 32'hFFFF_FFFF;
            end
            default: begin
                aligned_s   = 1'b0;
                lane_s      = 4'b0000;
                size_mask_s = 32'h0000_0000;
            end
        endcase
        acc_ok_s = hit_s & aligned_s;
        for (int b = 0; b < 4; b++) begin
            lane_mask_s[8*b +: 8] = {8{lane_s[b]}};
        end
        // Write data arrives in the low lanes and is moved to the addressed lanes
        wdata_s = stray_data_i << shift_s;
        wbits_s = GPIO_W'(wdata_s & lane_mask_s);
        wmask_s = GPIO_W'(lane_mask_s);
    end

    // Read-back mux; SET/CLR and rejected accesses return zero
    always_comb begin
        case (reg_sel_s)
            REG_OUT:   rreg_s = zext(out_r);
            REG_OE:    rreg_s = zext(oe_r);
            REG_IN:    rreg_s = zext(in_s);
            REG_RISE:  rreg_s = zext(rise_r);
            REG_FALL:  rreg_s = zext(fall_r);
            REG_IRQEN: rreg_s = zext(irqen_r);
            default:   rreg_s = 32'd0;
        endcase
        if (acc_ok_s && !stray_wr_i) begin
            rdata_s = (rreg_s >> shift_s) & size_mask_s;
        end else begin
            rdata_s = 32'd0;
        end
    end

    // Next register values from the write path and the edge detectors
    always_comb begin
        out_nxt_s   = out_r;
        oe_nxt_s    = oe_r;
        irqen_nxt_s = irqen_r;
        rise_clr_s  = {GPIO_W{1'b0}};
        fall_clr_s  = {GPIO_W{1'b0}};
        if (do_wr_s) begin
            case (reg_sel_s)
                REG_OUT:   out_nxt_s   = (out_r & ~wmask_s) | wbits_s;
                REG_OE:    oe_nxt_s    = (oe_r & ~wmask_s) | wbits_s;
                REG_RISE:  rise_clr_s  = wbits_s;
                REG_FALL:  fall_clr_s  = wbits_s;
                REG_IRQEN: irqen_nxt_s = (irqen_r & ~wmask_s) | wbits_s;
                REG_SET:   out_nxt_s   = out_r | wbits_s;
                REG_CLR:   out_nxt_s   = out_r & ~wbits_s;
                default:   out_nxt_s   = out_r;
            endcase
        end else begin
            out_nxt_s = out_r;
        end
        // A fresh edge overrides a clear of the same bit
        rise_nxt_s = (rise_r & ~rise_clr_s) | (in_s & ~prev_r);
        fall_nxt_s = (fall_r & ~fall_clr_s) | (~in_s & prev_r);
        irq_nxt_s  = |((rise_nxt_s | fall_nxt_s) & irqen_nxt_s);
    end

    // Bus handshake: accept in IDLE, pulse done in ACK, wait for release in DRAIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
            data_r  <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (stray_en_i) begin
                        data_r  <= rdata_s;
                        done_r  <= 1'b1;
                        state_r <= ACK;
                    end
                end
                ACK: begin
                    done_r  <= 1'b0;
                    state_r <= DRAIN;
                end
                DRAIN: begin
                    if (!stray_en_i) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Register file, edge history and interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r   <= {GPIO_W{1'b0}};
            oe_r    <= {GPIO_W{1'b0}};
            rise_r  <= {GPIO_W{1'b0}};
            fall_r  <= {GPIO_W{1'b0}};
            irqen_r <= {GPIO_W{1'b0}};
            prev_r  <= {GPIO_W{1'b0}};
            irq_r   <= 1'b0;
        end else begin
            out_r   <= out_nxt_s;
            oe_r    <= oe_nxt_s;
            rise_r  <= rise_nxt_s;
            fall_r  <= fall_nxt_s;
            irqen_r <= irqen_nxt_s;
            prev_r  <= in_s;
            irq_r   <= irq_nxt_s;
        end
    end

    // Input synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {GPIO_W{1'b0}};
            end
        end else begin
            sync_r[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign stray_data_o = data_r;
    assign stray_done_o = done_r;
    assign gpio_o       = out_r;
    assign gpio_oe_o    = oe_r;
    assign irq_o        = irq_r;

endmodule

// File: tb/tb_dumbrv_gpio_ext.sv
// Randomised bench for dumbrv_gpio_ext with a register-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_dumbrv_gpio_ext;

    localparam int          GW    = 16;
    localparam int          SS    = 3;
    localparam logic [15:0] BASE  = 16'hF000;
    localparam logic [31:0] GMASK = 32'h0000_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stray_en_i = 1'b0;
    logic          stray_wr_i = 1'b0;
    logic [15:0]   stray_addr_i = 16'd0;
    logic [2:0]    stray_size_i = 3'd0;
    logic [31:0]   stray_data_i = 32'd0;
    logic [31:0]   stray_data_o;
    logic          stray_done_o;
    logic [GW-1:0] gpio_i = '0;
    logic [GW-1:0] gpio_o;
    logic [GW-1:0] gpio_oe_o;
    logic          irq_o;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    bit rand_pins = 1'b0;
    logic [31:0] rd;
    logic [15:0] ra;
    logic [2:0]  rs;

    dumbrv_gpio_ext #(.GPIO_W(GW), .SYNC_STAGES(SS), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .stray_en_i(stray_en_i), .stray_wr_i(stray_wr_i), .stray_addr_i(stray_addr_i),
        .stray_size_i(stray_size_i), .stray_data_i(stray_data_i),
        .stray_data_o(stray_data_o), .stray_done_o(stray_done_o),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: registers as plain words, synchroniser as a delay queue
    logic [31:0] m_out = 0, m_oe = 0, m_rise = 0, m_fall = 0, m_irqen = 0;
    logic [31:0] m_in = 0, m_prev = 0, m_data = 0;
    logic        m_done = 0, m_busy = 0, m_irq = 0;
    logic [31:0] sq[$];
    logic [31:0] e_rise, e_fall, c_rise, c_fall, v, wv, wm;
    int          off, bp, nb;
    bit          ok;

    function automatic logic [31:0] m_reg(input int idx);
        case (idx)
            0: return m_out;
            1: return m_oe;
            2: return m_in;
            3: return m_rise;
            4: return m_fall;
            5: return m_irqen;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out = 0; m_oe = 0; m_rise = 0; m_fall = 0; m_irqen = 0;
            m_in = 0; m_prev = 0; m_data = 0; m_done = 0; m_busy = 0; m_irq = 0;
            sq.delete();
            for (int i = 0; i < SS - 1; i++) sq.push_back(32'd0);
        end else begin
            e_rise = m_in & ~m_prev;
            e_fall = ~m_in & m_prev;
            c_rise = 32'd0;
            c_fall = 32'd0;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_busy) begin
                if (!stray_en_i) m_busy = 1'b0;
            end else if (stray_en_i) begin
                m_done = 1'b1;
                m_busy = 1'b1;
                off = int'(stray_addr_i) - int'(BASE);
                bp  = int'(stray_addr_i[1:0]);
                nb  = (stray_size_i == 3'd0) ? 1 : (stray_size_i == 3'd1) ? 2 :
                      (stray_size_i == 3'd2) ? 4 : 0;
                ok  = (off >= 0) && (off < 32) && (nb != 0);
                if (ok) ok = ((bp % nb) == 0);
                m_data = 32'd0;
                if (ok && !stray_wr_i) begin
                    v = m_reg(off / 4) >> (8 * bp);
                    for (int k = 0; k < 4; k++) if (k >= nb) v[8*k +: 8] = 8'h00;
                    m_data = v;
                end else if (ok) begin
                    wv = 32'd0;
                    wm = 32'd0;
                    for (int k = 0; k < nb; k++) begin
                        wm[8*(bp+k) +: 8] = 8'hFF;
                        wv[8*(bp+k) +: 8] = stray_data_i[8*k +: 8];
                    end
                    case (off / 4)
                        0: m_out   = ((m_out & ~wm) | wv) & GMASK;
                        1: m_oe    = ((m_oe & ~wm) | wv) & GMASK;
                        3: c_rise  = wv & GMASK;
                        4: c_fall  = wv & GMASK;
                        5: m_irqen = ((m_irqen & ~wm) | wv) & GMASK;
                        6: m_out   = (m_out | wv) & GMASK;
                        7: m_out   = (m_out & ~wv) & GMASK;
                        default: ;
                    endcase
                end
            end
            m_rise = ((m_rise & ~c_rise) | e_rise) & GMASK;
            m_fall = ((m_fall & ~c_fall) | e_fall) & GMASK;
            m_prev = m_in;
            sq.push_back(32'(gpio_i));
            m_in = sq.pop_front();
            m_irq = |((m_rise | m_fall) & m_irqen);
        end
    end

    // Compare process: every output against the model on every cycle
    always @(negedge clk) begin
        if (chk_on) begin
            chk("done",  32'(stray_done_o), 32'(m_done));
            chk("rdata", stray_data_o, m_data);
            chk("gpio_o", 32'(gpio_o), m_out);
            chk("gpio_oe", 32'(gpio_oe_o), m_oe);
            chk("irq", 32'(irq_o), 32'(m_irq));
        end
    end

    task automatic pins();
        if (rand_pins && $urandom_range(0, 3) == 0) gpio_i = GW'($urandom);
    endtask

    task automatic bus(input logic wr, input logic [15:0] a, input logic [2:0] sz,
                       input logic [31:0] d, input int hold, output logic [31:0] rdv);
        int dones;
        @(negedge clk); pins();
        stray_en_i = 1'b1; stray_wr_i = wr; stray_addr_i = a;
        stray_size_i = sz; stray_data_i = d;
        @(negedge clk); pins();
        chk("latency", 32'(stray_done_o), 32'd1);
        rdv = stray_data_o;
        dones = int'(stray_done_o);
        for (int i = 1; i < hold; i++) begin
            // Request fields wander while held; none of it may be acted on
            stray_wr_i = 1'($urandom); stray_addr_i = 16'($urandom);
            stray_size_i = 3'($urandom); stray_data_i = $urandom;
            @(negedge clk); pins();
            dones += int'(stray_done_o);
        end
        chk("one_done", 32'(dones), 32'd1);
        stray_en_i = 1'b0;
        repeat (2) begin @(negedge clk); pins(); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_done", 32'(stray_done_o), 32'd0);
        chk("rst_data", stray_data_o, 32'd0);
        chk("rst_gpio", 32'(gpio_o), 32'd0);
        chk("rst_oe", 32'(gpio_oe_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        rst = 1'b0;
        chk_on = 1'b1;

        bus(1'b1, BASE, 3'd2, 32'h0000_00A5, 1, rd);
        chk("out_a5", 32'(gpio_o), 32'h0000_00A5);
        bus(1'b0, BASE, 3'd2, 32'd0, 1, rd);
        chk("rd_out_a5", rd, 32'h0000_00A5);

        bus(1'b1, BASE, 3'd2, 32'h0000_00F0, 1, rd);
        bus(1'b1, BASE + 16'h18, 3'd2, 32'h0000_000F, 1, rd);
        chk("set_ff", 32'(gpio_o), 32'h0000_00FF);
        bus(1'b1, BASE + 16'h1C, 3'd2, 32'h0000_0081, 1, rd);
        chk("clr_7e", 32'(gpio_o), 32'h0000_007E);
        bus(1'b1, BASE + 16'h04, 3'd2, 32'hFFFF_1234, 1, rd);
        chk("oe_upper", 32'(gpio_oe_o), 32'h0000_1234);

        bus(1'b1, BASE, 3'd2, 32'd0, 1, rd);
        bus(1'b1, BASE + 16'h01, 3'd0, 32'h0000_005A, 1, rd);
        bus(1'b0, BASE, 3'd2, 32'd0, 1, rd);
        chk("byte_lane", rd, 32'h0000_5A00);
        bus(1'b0, BASE + 16'h01, 3'd1, 32'd0, 1, rd);
        chk("half_misal", rd, 32'd0);
        bus(1'b0, BASE + 16'h01, 3'd0, 32'd0, 1, rd);
        chk("byte_rd", rd, 32'h0000_005A);

        bus(1'b1, BASE + 16'h18, 3'd2, 32'h0000_0001, 5, rd);
        chk("held_set", 32'(gpio_o), 32'h0000_5A01);
        bus(1'b0, BASE + 16'h20, 3'd2, 32'd0, 1, rd);
        chk("unmapped", rd, 32'd0);
        bus(1'b0, BASE, 3'd3, 32'd0, 1, rd);
        chk("size3", rd, 32'd0);
        bus(1'b1, BASE + 16'h02, 3'd2, 32'hFFFF_FFFF, 1, rd);
        chk("word_misal", 32'(gpio_o), 32'h0000_5A01);

        bus(1'b1, BASE + 16'h14, 3'd2, 32'h0000_0008, 1, rd);
        gpio_i = 16'h0008;
        repeat (SS) @(negedge clk);
        chk("irq_early", 32'(irq_o), 32'd0);
        @(negedge clk);
        chk("irq_rise", 32'(irq_o), 32'd1);
        bus(1'b0, BASE + 16'h0C, 3'd2, 32'd0, 1, rd);
        chk("rise_rd", rd, 32'h0000_0008);
        bus(1'b1, BASE + 16'h0C, 3'd2, 32'h0000_0008, 1, rd);
        chk("irq_w1c", 32'(irq_o), 32'd0);

        gpio_i = 16'h0000;
        repeat (SS + 3) @(negedge clk);
        bus(1'b1, BASE + 16'h10, 3'd2, 32'h0000_FFFF, 1, rd);
        gpio_i = 16'h0008;
        repeat (SS - 1) @(negedge clk);
        bus(1'b1, BASE + 16'h0C, 3'd2, 32'h0000_0008, 1, rd);
        bus(1'b0, BASE + 16'h0C, 3'd2, 32'd0, 1, rd);
        chk("edge_wins", rd, 32'h0000_0008);

        @(negedge clk);
        stray_en_i = 1'b1; stray_wr_i = 1'b1; stray_addr_i = BASE;
        stray_size_i = 3'd2; stray_data_i = 32'h0000_FFFF;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_ack_done", 32'(stray_done_o), 32'd0);
        chk("rst_ack_gpio", 32'(gpio_o), 32'd0);
        chk("rst_ack_irq", 32'(irq_o), 32'd0);
        stray_en_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus(1'b0, BASE + 16'h14, 3'd2, 32'd0, 1, rd);
        chk("rst_irqen", rd, 32'd0);
        bus(1'b0, BASE, 3'd2, 32'd0, 1, rd);
        chk("rst_out", rd, 32'd0);
        repeat (SS + 2) @(negedge clk);
        bus(1'b0, BASE + 16'h0C, 3'd2, 32'd0, 1, rd);
        chk("post_rst_rise", rd, 32'h0000_0008);

        rand_pins = 1'b1;
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 7))
                0:       ra = 16'($urandom);
                1:       ra = BASE + 16'h20 + 16'($urandom_range(0, 31));
                default: ra = BASE + 16'($urandom_range(0, 31));
            endcase
            rs = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            bus(1'($urandom), ra, rs, $urandom, $urandom_range(1, 4), rd);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dumbrv_gpio_ext.md
DUMBRV_GPIO_EXT -- requirements
Module: dumbrv_gpio_ext

Interface
REQ-001 SHALL have parameter GPIO_W, default 8, meaning GPIO pin count, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning input synchroniser depth, legal range 2..4.
REQ-003 SHALL have parameter BASE_ADDR, default 16'hF000, meaning stray-bus base address, 32-byte aligned.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic rises on it.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port stray_en_i, input, 1 bit: request level, held by the requester until done.
REQ-007 SHALL have port stray_wr_i, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port stray_addr_i, input, 16 bits: byte address.
REQ-009 SHALL have port stray_size_i, input, 3 bits: 0 = byte, 1 = half, 2 = word.
REQ-010 SHALL have port stray_data_i, input, 32 bits: write data.
REQ-011 SHALL have port stray_data_o, output, 32 bits: read data.
REQ-012 SHALL have port stray_done_o, output, 1 bit: single-cycle completion pulse.
REQ-013 SHALL have port gpio_i, input, GPIO_W bits: asynchronous pins.
REQ-014 SHALL have port gpio_o, output, GPIO_W bits: output pin values.
REQ-015 SHALL have port gpio_oe_o, output, GPIO_W bits: output enables.
REQ-016 SHALL have port irq_o, output, 1 bit: level interrupt.

Function
REQ-017 SHALL map these word registers at offsets from BASE_ADDR:
- 0x00 OUT (RW)
- 0x04 OE (RW)
- 0x08 IN (RO, synchronised)
- 0x0C RISE (W1C)
- 0x10 FALL (W1C)
- 0x14 IRQEN (RW)
- 0x18 SET (WO, OUT |= data)
- 0x1C CLR (WO, OUT &= ~data)
REQ-018 SHALL implement only bits [GPIO_W-1:0] of each register; upper bits read 0 and ignore writes.
REQ-019 SHALL use FSM states IDLE, ACK and DRAIN:
- IDLE: when stray_en_i=1, perform the access, go to ACK.
- ACK: stray_done_o=1 for exactly this cycle, go to DRAIN.
- DRAIN: wait until stray_en_i=0, then go to IDLE.
REQ-020 SHALL give request-to-done latency of exactly 1 cycle: request sampled in cycle N, done in cycle N+1.
REQ-021 SHALL hold stray_data_o stable from the done cycle until the next access; stray_data_o = 0 on writes.
REQ-022 SHALL return reads as register >> (8*addr[1:0]), masked to the access size.
REQ-023 SHALL apply writes only to byte lanes selected by size and addr[1:0]; data is lane-aligned from stray_data_i[7:0] upward.
REQ-024 SHALL treat misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0), size>2, and unmapped offsets as: done still pulses, read returns 0, write has no effect.
REQ-025 SHALL treat writes to IN as no-ops and reads of SET/CLR as returning 0.
REQ-026 SHALL synchronise gpio_i through SYNC_STAGES flops; IN = last stage.
REQ-027 SHALL set RISE[i] when the last stage is 1 and the previous sampled value was 0; FALL[i] analogously for 1-to-0.
REQ-028 SHALL let edge set win over a same-cycle W1C clear of the same bit.
REQ-029 SHALL drive gpio_o = OUT and gpio_oe_o = OE registered, updating the cycle after the write is sampled.
REQ-030 SHALL drive irq_o = |((RISE | FALL) & IRQEN), registered.
REQ-031 SHALL perform no access while in ACK or DRAIN, even if request inputs change.

Reset
REQ-032 SHALL, while rst=1, force the FSM to IDLE and set OUT, OE, RISE, FALL, IRQEN, synchroniser flops, stray_data_o, stray_done_o and irq_o to 0.
REQ-033 SHALL, on reset asserted mid-access, drop stray_done_o immediately and discard any pending write.
REQ-034 SHALL generate no spurious edges from the first synchronised sample after reset; the previous-sample register resets to 0, so only pins high after reset give a RISE.

Verification
REQ-035 SHALL cover: word write 0x000000A5 to OUT -> done pulses 1 cycle later; gpio_o=0xA5 on the next cycle; read OUT returns 0x000000A5.
REQ-036 SHALL cover: OUT=0xF0, SET 0x0F -> 0xFF; then CLR 0x81 -> gpio_o=0x7E.
REQ-037 SHALL cover: gpio_i[3] goes 0->1, IRQEN=0x08 -> RISE=0x08 after SYNC_STAGES+1 cycles, irq_o=1; W1C 0x08 to RISE -> irq_o=0.
REQ-038 SHALL cover: byte write 0x5A at BASE+0x01 to OUT (GPIO_W=16) -> OUT=0x5A00; halfword read at BASE+0x01 -> done pulses, data 0.
REQ-039 SHALL cover: stray_en_i held 5 cycles -> exactly one done pulse and one write effect; an unmapped offset 0x20 read -> done pulses, data 0.
REQ-040 SHALL cover: rst asserted during ACK -> done low in the same cycle, all registers 0; edge and W1C in the same cycle -> bit remains set.
